// File: rtl/ram_port_master_pkg.sv
// rtl/ram_port_master_pkg.sv - shared defaults, response entry and FIFO sizing for ram_port_master
// Optional feature macro: RAM_PORT_MASTER_WR_ACK_EN (write acknowledge responses)
package ram_port_master_pkg;

   localparam int RPM_DATA_WIDTH = 8;
   localparam int RPM_ADDR_WIDTH = 8;
   localparam int RPM_RSP_DEPTH  = 2;

   // Count must represent DEPTH itself, hence one bit beyond the pointer width.
   function automatic int rsp_cnt_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

   localparam int RPM_CNT_WIDTH = rsp_cnt_width(RPM_RSP_DEPTH);

   typedef struct packed {
`ifdef RAM_PORT_MASTER_WR_ACK_EN
      logic                      wr;
`endif
      logic [RPM_DATA_WIDTH-1:0] data;
   } rsp_entry_t;

endpackage

// File: rtl/ram_port_master_rsp_fifo.sv
// rtl/ram_port_master_rsp_fifo.sv - response FIFO with push/pop/count and registered head
// Holds one flat entry per response; the top packs the optional write flag above the data.
module ram_port_master_rsp_fifo
   import ram_port_master_pkg::*;
#(
   parameter int WIDTH = RPM_DATA_WIDTH,
   parameter int DEPTH = RPM_RSP_DEPTH,
   parameter int CNT_W = rsp_cnt_width(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic [CNT_W-1:0] count
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         mem_d[wr_ptr_q] = push_data;
         wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign head  = mem_q[rd_ptr_q];
   assign count = count_q;

endmodule

// File: rtl/ram_port_master.sv
// rtl/ram_port_master.sv - request/response initiator for one port of the dual-port RAM
// Optional feature macro: RAM_PORT_MASTER_WR_ACK_EN (writes also return an acknowledge)
module ram_port_master
   import ram_port_master_pkg::*;
#(
   parameter int DATA_WIDTH = RPM_DATA_WIDTH,
   parameter int ADDR_WIDTH = RPM_ADDR_WIDTH,
   parameter int RSP_DEPTH  = RPM_RSP_DEPTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_data,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_WIDTH-1:0] rsp_data,
`ifdef RAM_PORT_MASTER_WR_ACK_EN
   output logic                  rsp_wr,
`endif
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic [DATA_WIDTH-1:0] ram_data,
   output logic                  ram_we,
   input  logic [DATA_WIDTH-1:0] ram_q
);

   localparam int CNT_W = rsp_cnt_width(RSP_DEPTH);
`ifdef RAM_PORT_MASTER_WR_ACK_EN
   localparam int ENTRY_W = DATA_WIDTH + 1;
`else
   localparam int ENTRY_W = DATA_WIDTH;
`endif

   logic               inflight_q, inflight_d;
`ifdef RAM_PORT_MASTER_WR_ACK_EN
   logic               inflight_wr_q, inflight_wr_d;
`endif
   logic               accept;
   logic               pop;
   logic [CNT_W-1:0]   count;
   logic [CNT_W:0]     occupancy;
   logic [ENTRY_W-1:0] head;
   logic [ENTRY_W-1:0] push_entry;

   always_comb begin
      rsp_valid = !rst && (count != '0);
      pop       = rsp_valid && rsp_ready;
      // Slots already promised: queued + the read whose data arrives next cycle, minus today's pop.
      occupancy = {1'b0, count} + {{CNT_W{1'b0}}, inflight_q} - {{CNT_W{1'b0}}, pop};
      req_ready = !rst && (occupancy < (CNT_W+1)'(RSP_DEPTH));
      accept    = req_valid && req_ready;
      ram_addr  = req_addr;
      ram_data  = req_data;
      ram_we    = accept && req_we;
      rsp_data  = head[DATA_WIDTH-1:0];
`ifdef RAM_PORT_MASTER_WR_ACK_EN
      inflight_d    = accept;
      inflight_wr_d = accept && req_we;
      push_entry    = {inflight_wr_q, ram_q};
      rsp_wr        = rsp_valid && head[DATA_WIDTH];
`else
      inflight_d    = accept && !req_we;
      push_entry    = ram_q;
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         inflight_q    <= 1'b0;
`ifdef RAM_PORT_MASTER_WR_ACK_EN
         inflight_wr_q <= 1'b0;
`endif
      end else begin
         inflight_q    <= inflight_d;
`ifdef RAM_PORT_MASTER_WR_ACK_EN
         inflight_wr_q <= inflight_wr_d;
`endif
      end
   end

   ram_port_master_rsp_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (RSP_DEPTH),
      .CNT_W (CNT_W)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (inflight_q),
      .push_data (push_entry),
      .pop       (pop),
      .head      (head),
      .count     (count)
   );

endmodule

// File: tb/tb_ram_port_master.sv
// tb/tb_ram_port_master.sv - directed bench for ram_port_master with a write-first RAM port model
// Optional feature macro: RAM_PORT_MASTER_WR_ACK_EN
`timescale 1ns/1ps
module tb_ram_port_master;

   localparam int DW    = 8;
   localparam int AW    = 8;
   localparam int DEPTH = 2;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          req_valid = 1'b0;
   logic          req_ready;
   logic          req_we = 1'b0;
   logic [AW-1:0] req_addr = '0;
   logic [DW-1:0] req_data = '0;
   logic          rsp_valid;
   logic          rsp_ready = 1'b1;
   logic [DW-1:0] rsp_data;
   logic          rsp_wr_obs;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_data;
   logic          ram_we;
   logic [DW-1:0] ram_q;

   ram_port_master #(
      .DATA_WIDTH (DW),
      .ADDR_WIDTH (AW),
      .RSP_DEPTH  (DEPTH)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_we    (req_we),
      .req_addr  (req_addr),
      .req_data  (req_data),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_data  (rsp_data),
`ifdef RAM_PORT_MASTER_WR_ACK_EN
      .rsp_wr    (rsp_wr_obs),
`endif
      .ram_addr  (ram_addr),
      .ram_data  (ram_data),
      .ram_we    (ram_we),
      .ram_q     (ram_q)
   );
`ifndef RAM_PORT_MASTER_WR_ACK_EN
   assign rsp_wr_obs = 1'b0;
`endif

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // RAM port model: registered, write-first read.
   logic [DW-1:0] mem [256];
   always @(posedge clk) begin
      if (ram_we) begin
         mem[ram_addr] <= ram_data;
         ram_q         <= ram_data;
      end else begin
         ram_q <= mem[ram_addr];
      end
   end

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   logic [DW:0] rx_q[$];
   int          rx_cyc[$];

   always @(negedge clk) begin
      if (!rst) begin
         check("fifo_no_overflow", dut.u_fifo.count_q <= DEPTH, 1);
         if (rsp_valid && rsp_ready) begin
            rx_q.push_back({rsp_wr_obs, rsp_data});
            rx_cyc.push_back(cyc);
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       output int acc_cyc);
      bit done = 0;
      acc_cyc   = -1;
      req_valid = 1'b1;
      req_we    = we;
      req_addr  = a;
      req_data  = d;
      for (int t = 0; t < 20 && !done; t++) begin
         @(negedge clk);
         if (req_ready) begin
            done    = 1;
            acc_cyc = cyc;
         end
         @(posedge clk);
         #1;
      end
      req_valid = 1'b0;
      req_we    = 1'b0;
      check("send_accepted", done, 1);
   endtask

   int  c;
   int  k;
   bit  found;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = i[DW-1:0];

      // Reset held with a write request pending: nothing may reach the RAM.
      rst = 1'b1; req_valid = 1'b1; req_we = 1'b1; req_addr = 8'h33; req_data = 8'hEE;
      repeat (3) begin
         @(negedge clk);
         check("rst_ram_we", ram_we, 0);
         check("rst_req_ready", req_ready, 0);
         check("rst_rsp_valid", rsp_valid, 0);
      end
      @(posedge clk); #1;
      rst = 1'b0; req_valid = 1'b0; req_we = 1'b0;
      @(negedge clk);
      check("post_rst_req_ready", req_ready, 1);
      check("post_rst_rsp_valid", rsp_valid, 0);
      check("rst_mem_untouched", mem[8'h33], 8'h33);
      @(posedge clk); #1;

      // Write then read with latency measurement.
      rsp_ready = 1'b1;
      send(1'b1, 8'h10, 8'h5A, c);
      idle(4);
      check("wr_mem_5a", mem[8'h10], 8'h5A);
      rx_q.delete(); rx_cyc.delete();
      send(1'b0, 8'h10, 8'h00, c);
      found = 0;
      for (int t = 0; t < 10; t++) begin
         @(negedge clk);
         if (rsp_valid && !found) begin
            found = 1;
            check("rd_latency", cyc, c + 2);
            check("rd_data_5a", rsp_data, 8'h5A);
         end
      end
      check("rd_found", found, 1);
      @(posedge clk); #1;
      check("rd_one_rsp", rx_q.size(), 1);

      // Back-to-back reads at full throughput.
      rx_q.delete(); rx_cyc.delete();
      req_valid = 1'b1; req_we = 1'b0;
      for (int i = 0; i < 16; i++) begin
         req_addr = i[AW-1:0];
         @(negedge clk);
         check("stream_ready", req_ready, 1);
         @(posedge clk); #1;
      end
      req_valid = 1'b0;
      idle(5);
      check("stream_count", rx_q.size(), 16);
      for (int i = 0; i < 16 && i < rx_q.size(); i++) begin
         check("stream_data", rx_q[i], i);
         check("stream_consecutive", rx_cyc[i], rx_cyc[0] + i);
      end

      // Backpressure: exactly DEPTH accepts, then release without loss.
      rx_q.delete(); rx_cyc.delete();
      rsp_ready = 1'b0; req_valid = 1'b1; k = 0;
      for (int t = 0; t < 6; t++) begin
         req_addr = k[AW-1:0];
         @(negedge clk);
         if (req_ready) k++;
         @(posedge clk); #1;
      end
      check("stall_accepts", k, DEPTH);
      @(negedge clk);
      check("stall_ready_low", req_ready, 0);
      @(posedge clk); #1;
      rsp_ready = 1'b1;
      for (int t = 0; t < 40 && k < 8; t++) begin
         req_addr = k[AW-1:0];
         @(negedge clk);
         if (req_ready) k++;
         @(posedge clk); #1;
      end
      req_valid = 1'b0;
      idle(6);
      check("release_count", rx_q.size(), 8);
      for (int i = 0; i < 8 && i < rx_q.size(); i++) check("release_order", rx_q[i], i);

      // Reset pulse with one response queued and one read in flight.
      rx_q.delete(); rx_cyc.delete();
      rsp_ready = 1'b0;
      send(1'b0, 8'h03, 8'h00, c);
      send(1'b0, 8'h04, 8'h00, c);
      rst = 1'b1;
      @(negedge clk);
      check("pulse_rsp_valid_in_rst", rsp_valid, 0);
      check("pulse_req_ready_in_rst", req_ready, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("pulse_rsp_valid_after", rsp_valid, 0);
      check("pulse_req_ready_after", req_ready, 1);
      @(posedge clk); #1;
      rsp_ready = 1'b1;
      send(1'b0, 8'h0A, 8'h00, c);
      idle(5);
      check("pulse_rsp_count", rx_q.size(), 1);
      if (rx_q.size() > 0) check("pulse_rsp_data", rx_q[0], 9'h00A);

      // Write responses: acknowledge with written data, or none at all.
      rx_q.delete(); rx_cyc.delete();
`ifdef RAM_PORT_MASTER_WR_ACK_EN
      send(1'b1, 8'h20, 8'hC3, c);
      send(1'b0, 8'h20, 8'h00, c);
      idle(5);
      check("wrack_count", rx_q.size(), 2);
      if (rx_q.size() > 1) begin
         check("wrack_rsp0", rx_q[0], 9'h1C3);
         check("wrack_rsp1", rx_q[1], 9'h0C3);
      end
`else
      send(1'b1, 8'h21, 8'h77, c);
      idle(5);
      check("wr_no_rsp", rx_q.size(), 0);
      check("wr_mem_77", mem[8'h21], 8'h77);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
